pipelined_parallel_counter: RTL
===============================

PIPELINED_PARALLEL_COUNTER -- requirements
Module: pipelined_parallel_counter

Interface
REQ-001 SHALL provide parameter N, default 6: number of input bits to count, N >= 3.
REQ-002 SHALL provide parameter STAGES, default 2: pipeline register stages, 1..4.
REQ-003 SHALL provide parameter ACC_W, default 16: accumulator width, used only when PCNT_ACCUM_EN is defined.
REQ-004 SHALL define W = clog2(N+1) as the count width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_bits  in  N  bits to count.
REQ-009 in_valid  in  1  in_bits valid.
REQ-010 in_ready  out  1  block accepts a beat this cycle.
REQ-011 out_count  out  W  popcount of the accepted beat.
REQ-012 out_valid  out  1  out_count valid.
REQ-013 out_ready  in  1  downstream accepts out_count.
REQ-014 Present only under PCNT_ACCUM_EN: in_last in 1 (ends group), out_last out 1, out_acc out ACC_W (running group sum).

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready, and a result delivered when out_valid && out_ready.
REQ-016 advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally.
REQ-017 Each stage SHALL hold a valid bit; on advance, all stages shift one place (bubbles included); without advance, all stages hold.
REQ-018 Latency SHALL be exactly STAGES advancing cycles from acceptance to out_valid; throughput one beat per cycle when out_ready=1.
REQ-019 out_count SHALL equal the number of 1s in the accepted in_bits, exact for all N (all-ones gives N, all-zeros gives 0).
REQ-020 Compression SHALL use 3:2 carry-save layers until two rows remain, then one final carry-propagate add; layers SHALL be distributed across STAGES as evenly as possible.
REQ-021 out_count and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 An in_valid beat arriving while in_ready=0 SHALL NOT be captured; the source holds it.

Reset
REQ-023 On rst, every stage valid bit, out_valid, out_count, out_last and out_acc SHALL go to 0 on the next clock edge.
REQ-024 Beats in flight at reset SHALL be discarded; no output is produced for them.
REQ-025 in_ready SHALL be 1 in the cycle after reset, because the output stage is empty.

Configuration
REQ-026 Macro PCNT_ACCUM_EN: when defined, in_last is piped alongside the data to out_last.
REQ-027 With PCNT_ACCUM_EN, out_acc SHALL equal the sum of out_count over the current group, including the present beat.
REQ-028 With PCNT_ACCUM_EN, out_acc SHALL saturate at 2^ACC_W-1.
REQ-029 With PCNT_ACCUM_EN, the group sum SHALL clear after a delivered beat with out_last=1.
REQ-030 Without PCNT_ACCUM_EN, the ports in_last, out_last and out_acc and all accumulator logic SHALL be absent.

Structure
REQ-031 A shared package mult_pkg SHALL hold the clog2 function and the constants for count-width and stage-split computation, for reuse by the other multiplier blocks.
REQ-032 One sub-module, csa_layer (parametrised 3:2 compressor row of full adders), SHALL be instantiated once per compression layer.

Verification
REQ-033 N=6, STAGES=2, out_ready=1: in_bits=6'b111111 at cycle 0 -> out_count=6, out_valid=1 at cycle 2; 6'b000000 -> 0; 6'b101001 -> 3.
REQ-034 Back-to-back beats 6'b000001, 6'b000011, 6'b000111 -> out_count 1, 2, 3 on consecutive cycles with no bubbles.
REQ-035 Hold out_ready=0 for 3 cycles after the first result -> out_count stays 1; in_ready=0 once the output is full; no beat is lost or duplicated after release.
REQ-036 Assert rst while 2 beats are in flight -> out_valid=0 next cycle, no stale output afterwards, in_ready=1.
REQ-037 N=15, STAGES=3: random 10k beats checked against a popcount model with random out_ready.
REQ-038 With PCNT_ACCUM_EN, ACC_W=4: beats counting 6, 3, 0 (last on third) -> out_acc 6, 9, 9, next beat restarts from its own count. Beats 6, 6, 6 -> out_acc 6, 12, 15 (saturation).

Source files
------------

// File: rtl/mult_pkg.sv
// Shared sizing helpers for the counter / multiplier blocks.
// Count width, carry-save row counts and layer-to-stage split.
package mult_pkg;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   function automatic int cnt_w(input int n);
      return clog2(n + 1);
   endfunction

   function automatic int csa_rows(input int rows);
      return 2 * (rows / 3) + rows % 3;
   endfunction

   function automatic int rows_at(input int n, input int layer);
      int r;
      r = n;
      for (int i = 0; i < layer; i++) r = csa_rows(r);
      return r;
   endfunction

   function automatic int csa_layers(input int n);
      int r;
      int l;
      r = n;
      l = 0;
      for (int i = 0; i < n && r > 2; i++) begin
         r = csa_rows(r);
         l++;
      end
      return l;
   endfunction

   // ops = CSA layers plus the final add, spread evenly
   function automatic int op_stage(input int k, input int nops,
                                   input int stages);
      return (k * stages) / nops;
   endfunction

   function automatic int last_op(input int s, input int nops,
                                  input int stages);
      int r;
      r = -1;
      for (int k = 0; k < nops; k++)
         if (op_stage(k, nops, stages) == s) r = k;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_parallel_counter_csa_layer.sv
// One 3:2 carry-save layer: rows taken in threes through full adders.
// Leftover rows pass through; rows above the result are zero.
module csa_layer
   import mult_pkg::*;
#(
   parameter int W    = 3,
   parameter int RIN  = 6,
   parameter int RMAX = 6
) (
   input  logic [RMAX*W-1:0] rows_in,
   output logic [RMAX*W-1:0] rows_out
);

   localparam int G   = RIN / 3;
   localparam int REM = RIN % 3;

   always_comb begin
      rows_out = '0;
      for (int g = 0; g < G; g++) begin
         rows_out[2*g*W +: W] = rows_in[3*g*W +: W]
                              ^ rows_in[(3*g+1)*W +: W]
                              ^ rows_in[(3*g+2)*W +: W];
         // carry weight is 2; the top carry bit cannot be set
         rows_out[(2*g+1)*W +: W] =
            ((rows_in[3*g*W +: W] & rows_in[(3*g+1)*W +: W])
           | (rows_in[3*g*W +: W] & rows_in[(3*g+2)*W +: W])
           | (rows_in[(3*g+1)*W +: W] & rows_in[(3*g+2)*W +: W]))
            << 1;
      end
      for (int r = 0; r < REM; r++)
         rows_out[(2*G+r)*W +: W] = rows_in[(3*G+r)*W +: W];
   end

   if (RIN < RMAX) begin : g_sink
      logic unused_in;
      assign unused_in = ^rows_in[RMAX*W-1:RIN*W];
   end

endmodule

// File: rtl/pipelined_parallel_counter.sv
// Pipelined popcount: CSA layers then one add, valid/ready output.
// Define PCNT_ACCUM_EN for in_last/out_last and a saturating group sum.
module pipelined_parallel_counter
   import mult_pkg::*;
#(
   parameter int N      = 6,
   parameter int STAGES = 2,
   parameter int ACC_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          in_bits,
   input  logic                  in_valid,
   output logic                  in_ready,
`ifdef PCNT_ACCUM_EN
   input  logic                  in_last,
   output logic                  out_last,
   output logic [ACC_W-1:0]      out_acc,
`endif
   output logic [cnt_w(N)-1:0]   out_count,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int W    = cnt_w(N);
   localparam int L    = csa_layers(N);
   localparam int NOPS = L + 1;
   localparam int RW   = N * W;

   if (N < 3 || STAGES < 1 || STAGES > 4 || ACC_W < 1)
   begin : g_bad_param
      $error("pipelined_parallel_counter: bad parameters");
   end

   logic              advance;
   logic [RW-1:0]     row_in;
   logic [RW-1:0]     op_in  [NOPS];
   logic [RW-1:0]     op_out [NOPS];
   logic [RW-1:0]     st_d   [1:STAGES];
   logic [RW-1:0]     st_q   [1:STAGES];
   logic [STAGES:1]   vld_q;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_q[STAGES];
   assign out_count = st_q[STAGES][W-1:0];

   always_comb begin
      row_in = '0;
      for (int i = 0; i < N; i++)
         row_in[i*W +: W] = {{(W-1){1'b0}}, in_bits[i] & in_valid};
   end

   for (genvar k = 0; k < NOPS; k++) begin : g_op
      localparam int S = op_stage(k, NOPS, STAGES);
      if (k == 0) begin : g_src
         assign op_in[k] = row_in;
      end else if (op_stage(k - 1, NOPS, STAGES) != S) begin : g_src
         assign op_in[k] = st_q[S];
      end else begin : g_src
         assign op_in[k] = op_out[k-1];
      end
      if (k < L) begin : g_csa
         csa_layer #(
            .W    (W),
            .RIN  (rows_at(N, k)),
            .RMAX (N)
         ) u_csa (
            .rows_in  (op_in[k]),
            .rows_out (op_out[k])
         );
      end else begin : g_add
         assign op_out[k] = {{(RW-W){1'b0}},
                             op_in[k][W-1:0] + op_in[k][2*W-1:W]};
      end
   end

   for (genvar s = 1; s <= STAGES; s++) begin : g_st
      localparam int LO = last_op(s - 1, NOPS, STAGES);
      if (LO >= 0) begin : g_d
         assign st_d[s] = op_out[LO];
      end else begin : g_d
         assign st_d[s] = st_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int s = 1; s <= STAGES; s++) st_q[s] <= '0;
      end else if (advance) begin
         vld_q[1] <= in_valid;
         for (int s = 2; s <= STAGES; s++) vld_q[s] <= vld_q[s-1];
         for (int s = 1; s <= STAGES; s++) st_q[s] <= st_d[s];
      end
   end

   logic unused_rows;
   assign unused_rows = ^{st_q[STAGES][RW-1:W], op_in[L][RW-1:2*W]};

`ifdef PCNT_ACCUM_EN
   localparam int SW = ((ACC_W > W) ? ACC_W : W) + 1;

   logic [STAGES:1]   lst_q;
   logic [ACC_W-1:0]  grp_q;
   logic [SW-1:0]     acc_sum;

   assign out_last = lst_q[STAGES];
   assign acc_sum  = SW'(grp_q) + SW'(out_count);
   assign out_acc  = (acc_sum > SW'({ACC_W{1'b1}}))
                   ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         lst_q <= '0;
         grp_q <= '0;
      end else begin
         if (advance) begin
            lst_q[1] <= in_last & in_valid;
            for (int s = 2; s <= STAGES; s++) lst_q[s] <= lst_q[s-1];
         end
         if (out_valid && out_ready)
            grp_q <= out_last ? '0 : out_acc;
      end
   end
`endif

endmodule
